mem_arbiter: RTL

- Sequences and shares the single-port 512 x 32 main memory between two requesters: instruction fetch (F, read-only) and load/store data (D, read/write).
- Sits between the control unit/datapath and the memory block, and owns the memory Read/Write/Address/Mdatain lines.
- Accounts for the memory's one-cycle registered read latency.
- Returns read data and a one-cycle acknowledge to each requester.
- Arbitrates round-robin so that neither requester starves.

---
 rtl/mem_arb_pkg.sv | 12 +
 rtl/mem_arbiter.sv | 115 +++++++++++
 2 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared widths, FSM encodings and grant codes for mem_arbiter
package mem_arb_pkg;
  localparam int DEF_ADDR_W = 9;
  localparam int DEF_DATA_W = 32;
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    RESP  = 2'b10
  } state_t;
  localparam logic GRANT_F = 1'b0;
  localparam logic GRANT_D = 1'b1;
endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin sharing of a single-port, one-cycle-latency memory
// between an instruction-fetch requester and a load/store requester.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_ack,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              grant
);
  state_t              state_q, state_d;
  logic                grant_q, grant_d, last_grant_q, last_grant_d, we_q, we_d;
  logic                mem_read_q, mem_read_d, mem_write_q, mem_write_d;
  logic                f_ack_q, f_ack_d, d_ack_q, d_ack_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d, f_rdata_q, f_rdata_d, d_rdata_q, d_rdata_d;
  logic                pick;
  // When both ask, the one not served last wins.
  assign pick = (f_req && d_req) ? ~last_grant_q : d_req;
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    f_ack_d      = 1'b0;
    d_ack_d      = 1'b0;
    f_rdata_d    = f_rdata_q;
    d_rdata_d    = d_rdata_q;
    unique case (state_q)
      IDLE: if (f_req || d_req) begin
        state_d     = ISSUE;
        grant_d     = pick;
        we_d        = (pick == GRANT_D) && d_we;
        mem_addr_d  = (pick == GRANT_D) ? d_addr : f_addr;
        mem_wdata_d = (pick == GRANT_D) ? d_wdata : mem_wdata_q;
        mem_read_d  = !we_d;
        mem_write_d = we_d;
      end
      ISSUE: begin
        state_d = RESP;
        f_ack_d = (grant_q == GRANT_F);
        d_ack_d = (grant_q == GRANT_D);
      end
      RESP: begin
        state_d      = IDLE;
        last_grant_d = grant_q;
        f_rdata_d    = (!we_q && grant_q == GRANT_F) ? mem_rdata : f_rdata_q;
        d_rdata_d    = (!we_q && grant_q == GRANT_D) ? mem_rdata : d_rdata_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q      <= IDLE;
      grant_q      <= GRANT_F;
      last_grant_q <= GRANT_D;
      we_q         <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      f_ack_q      <= 1'b0;
      d_ack_q      <= 1'b0;
      f_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      f_ack_q      <= f_ack_d;
      d_ack_q      <= d_ack_d;
      f_rdata_q    <= f_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end
  // Memory data arrives during the ack cycle, so it is forwarded then and held afterwards.
  assign f_rdata   = (f_ack_q && !we_q) ? mem_rdata : f_rdata_q;
  assign d_rdata   = (d_ack_q && !we_q) ? mem_rdata : d_rdata_q;
  assign f_ack     = f_ack_q;
  assign d_ack     = d_ack_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = (state_q != IDLE);
  assign grant     = grant_q;
endmodule
